page_queue_bank: RTL and testbench
==================================

# page_queue_bank

Parametrised bank of independent streaming FIFOs carrying a data word plus end-of-stream token per channel, used on the non-input stream edges of a page. It generalises the fixed 8×16-bit, depth-0/1 page queue to configurable channel count, data width and depth. It adds:
- a lookahead back-pressure threshold for producers with pipelined stall response;
- per-channel occupancy, end-token-pending and sticky overflow status.

## Interface
Parameters:
- NCH, 8, number of independent channels (≥1)
- DW, 16, data width per channel (≥1)
- DEPTH, 4, entries per channel FIFO; power of two, ≥2
- LOOKAHEAD, 0, slots reserved beyond the back-pressure point; 0 ≤ LOOKAHEAD < DEPTH
- CW, $clog2(DEPTH+1), occupancy field width (derived, not overridden)

Ports (channel i occupies bit i, or field [i*DW +: DW] / [i*CW +: CW]):
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- qin_d  in  NCH*DW  write data
- qin_e  in  NCH  end-of-stream token bit, travels with qin_d
- qin_v  in  NCH  write valid
- qin_b  out  NCH  back-pressure to producer (1 = stall)
- qout_d  out  NCH*DW  head data
- qout_e  out  NCH  head end-of-stream bit
- qout_v  out  NCH  head valid
- qout_b  in  NCH  back-pressure from consumer (1 = hold head)
- occ  out  NCH*CW  current entry count, 0..DEPTH
- eos_pend  out  NCH  1 while ≥1 stored entry has e=1
- ovf  out  NCH  sticky: a write was dropped because the FIFO was full

## Operation
- Each channel is fully independent. State per channel:
  - storage of DEPTH×(DW+1) bits
  - wr_ptr and rd_ptr, log2(DEPTH) bits each, wrapping modulo DEPTH
  - count, CW bits
  - ecount, CW bits: stored entries with e=1
  - ovf flag
- Write: qin_v=1 and count<DEPTH stores {qin_d,qin_e} at wr_ptr and increments wr_ptr. qin_b is not a qualifier; the producer may write while qin_b=1 using the LOOKAHEAD slack.
- Dropped write: qin_v=1 with count==DEPTH discards the word and sets ovf. This holds even if a read occurs in the same cycle; there is no full-bypass.
- Read: qout_v=1 and qout_b=0 pops the head and increments rd_ptr.
- Head outputs: qout_v = (count≠0); {qout_d,qout_e} = storage[rd_ptr]. Show-ahead: the head is presented without a read request. Data is don't-care when qout_v=0, but the bench checks it only when qout_v=1.
- Count update:
  - count += accepted write − read.
  - Simultaneous accepted write and read leaves count unchanged.
  - At empty, no read is possible, so a same-cycle write gives count=1.
- ecount increments on an accepted write with e=1 and decrements on a read of a head with e=1. eos_pend = (ecount≠0).
- qin_b = (count ≥ DEPTH−LOOKAHEAD), decoded from registered count only; no combinational path from any input.
- ovf clears only on reset.
- Reset (reset=0, asynchronous):
  - count, ecount, ptrs and ovf go to 0.
  - qout_v=0, eos_pend=0, occ=0.
  - qin_b=1 while reset is asserted, then follows the count rule (0 at release).
  - Assertion mid-stream discards all contents immediately; storage need not be cleared.

## Timing
- Write-to-qout_v latency: 1 cycle. A word written at edge N is visible on qout after N, and is readable in cycle N+1.
- Throughput: one write and one read per channel per cycle, sustained at any occupancy below DEPTH.
- qin_b, occ and eos_pend change on the edge after the causing write or read.
- With LOOKAHEAD=0, a producer honouring qin_b in the same cycle never overflows.
- With LOOKAHEAD=k, a producer may issue up to k further writes after qin_b rises without loss.
- Only timing paths from inputs to outputs: none; every output is a function of registers, plus reset for qin_b.

## Test plan
- Fill/drain, DEPTH=4, LOOKAHEAD=0, ch0 only:
  - Stimulus: write 0x0001..0x0004 with qout_b=1.
  - Required: occ=4 and qin_b=1 after the 4th edge. A 5th write (0x0005) sets ovf[0]=1 and is lost.
  - Then release qout_b. Required: reads 0x0001..0x0004 on consecutive cycles, then qout_v=0 and occ=0.
- Lookahead, DEPTH=8, LOOKAHEAD=2:
  - Stimulus: continuous writes.
  - Required: qin_b rises after the 6th write; writes 7–8 accepted with ovf=0; the 9th write sets ovf.
- Simultaneous read/write at full:
  - Stimulus: count=4, qin_v=1 and qout_b=0 in the same cycle.
  - Required: head popped, new word dropped, ovf=1, occ=3.
- End token tracking:
  - Stimulus: write {0x00AA,e=0}, {0x00BB,e=1}.
  - Required: eos_pend=1; after the first read still 1; after the second read (qout_e=1 observed) eos_pend=0.
- Channel independence and wrap, NCH=8:
  - Stimulus: ch3 streams 20 words at full rate with qout_b toggling every 3 cycles, while other channels stay idle.
  - Required: output order matches input order across pointer wrap; other channels keep occ=0, qin_b=0, qout_v=0.
- Async reset mid-operation:
  - Stimulus: with occ=3 and ovf=1, drive reset=0 between edges.
  - Required: qout_v=0, occ=0, ovf=0 and qin_b=1 immediately (before the next edge); qin_b=0 on the first cycle after release.

Source files
------------

// File: rtl/page_queue_bank.sv
// Bank of independent show-ahead FIFOs, each carrying a data word plus an end-of-stream bit,
// with lookahead back-pressure and per-channel occupancy, end-token and sticky overflow status.
module page_queue_bank #(
  parameter  int unsigned NCH       = 8,
  parameter  int unsigned DW        = 16,
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned LOOKAHEAD = 0,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*DW-1:0] qin_d,
  input  logic [NCH-1:0]    qin_e,
  input  logic [NCH-1:0]    qin_v,
  output logic [NCH-1:0]    qin_b,
  output logic [NCH*DW-1:0] qout_d,
  output logic [NCH-1:0]    qout_e,
  output logic [NCH-1:0]    qout_v,
  input  logic [NCH-1:0]    qout_b,
  output logic [NCH*CW-1:0] occ,
  output logic [NCH-1:0]    eos_pend,
  output logic [NCH-1:0]    ovf
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned THR = DEPTH - LOOKAHEAD;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DW:0]    r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_ecount;
    logic           r_ovf;
    logic           w_full;
    logic           w_wr;
    logic           w_rd;
    logic [DW:0]    w_head;
    logic [CW-1:0]  w_count_nxt;
    logic [CW-1:0]  w_ecount_nxt;

    // A full FIFO drops the write even when the head pops in the same cycle.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_wr   = qin_v[g] & ~w_full;
    assign w_rd   = (r_count != '0) & ~qout_b[g];
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
      w_count_nxt  = r_count;
      w_ecount_nxt = r_ecount + CW'(w_wr & qin_e[g]) - CW'(w_rd & w_head[0]);
      case ({w_wr, w_rd})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end

    // Storage carries no reset; validity is tracked solely by the count.
    always_ff @(posedge clock) begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {qin_d[g*DW +: DW], qin_e[g]};
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ecount <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        if (qin_v[g] & w_full) begin
          r_ovf <= 1'b1;
        end
        r_count  <= w_count_nxt;
        r_ecount <= w_ecount_nxt;
      end
    end

    // Outputs decode registered state only; qin_b is also forced high during reset.
    assign qin_b[g]             = ~reset | (r_count >= CW'(THR));
    assign qout_v[g]            = (r_count != '0);
    assign qout_d[g*DW +: DW]   = w_head[DW:1];
    assign qout_e[g]            = w_head[0];
    assign occ[g*CW +: CW]      = r_count;
    assign eos_pend[g]          = (r_ecount != '0);
    assign ovf[g]               = r_ovf;
  end

endmodule

// File: tb/tb_page_queue_bank.sv
// Directed self-checking bench for page_queue_bank: table-driven single-channel vectors on a
// default bank, plus lookahead, multi-channel streaming/wrap and async-reset sequences.
module tb_page_queue_bank;

  localparam int unsigned NCH = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 3;
  localparam int unsigned BCW = 4;

  logic              clock;
  logic              reset;

  logic [NCH*DW-1:0] a_qin_d;
  logic [NCH-1:0]    a_qin_e;
  logic [NCH-1:0]    a_qin_v;
  logic [NCH-1:0]    a_qin_b;
  logic [NCH*DW-1:0] a_qout_d;
  logic [NCH-1:0]    a_qout_e;
  logic [NCH-1:0]    a_qout_v;
  logic [NCH-1:0]    a_qout_b;
  logic [NCH*CW-1:0] a_occ;
  logic [NCH-1:0]    a_eos;
  logic [NCH-1:0]    a_ovf;

  logic [DW-1:0]     b_qin_d;
  logic [0:0]        b_qin_e;
  logic [0:0]        b_qin_v;
  logic [0:0]        b_qin_b;
  logic [DW-1:0]     b_qout_d;
  logic [0:0]        b_qout_e;
  logic [0:0]        b_qout_v;
  logic [0:0]        b_qout_b;
  logic [BCW-1:0]    b_occ;
  logic [0:0]        b_eos;
  logic [0:0]        b_ovf;

  int n_chk = 0;
  int n_err = 0;

  page_queue_bank #(.NCH(NCH), .DW(DW), .DEPTH(4), .LOOKAHEAD(0)) u_a (
    .clock(clock), .reset(reset),
    .qin_d(a_qin_d), .qin_e(a_qin_e), .qin_v(a_qin_v), .qin_b(a_qin_b),
    .qout_d(a_qout_d), .qout_e(a_qout_e), .qout_v(a_qout_v), .qout_b(a_qout_b),
    .occ(a_occ), .eos_pend(a_eos), .ovf(a_ovf)
  );

  page_queue_bank #(.NCH(1), .DW(DW), .DEPTH(8), .LOOKAHEAD(2)) u_b (
    .clock(clock), .reset(reset),
    .qin_d(b_qin_d), .qin_e(b_qin_e), .qin_v(b_qin_v), .qin_b(b_qin_b),
    .qout_d(b_qout_d), .qout_e(b_qout_e), .qout_v(b_qout_v), .qout_b(b_qout_b),
    .occ(b_occ), .eos_pend(b_eos), .ovf(b_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          ch;
    logic        v;
    logic [15:0] d;
    logic        e;
    logic        b;
    logic [2:0]  occ;
    logic        qb;
    logic        qv;
    logic [15:0] qd;
    logic        qe;
    logic        ovf;
    logic        eos;
  } vec_t;

  function automatic vec_t mk(int ch, logic v, logic [15:0] d, logic e, logic b,
                              logic [2:0] occ, logic qb, logic qv, logic [15:0] qd,
                              logic qe, logic ovf, logic eos);
    vec_t t;
    t.ch = ch; t.v = v; t.d = d; t.e = e; t.b = b;
    t.occ = occ; t.qb = qb; t.qv = qv; t.qd = qd; t.qe = qe; t.ovf = ovf; t.eos = eos;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input int ch, input logic v, input logic [15:0] d,
                         input logic e, input logic b);
    a_qin_d  = '0;
    a_qin_e  = '0;
    a_qin_v  = '0;
    a_qout_b = '1;
    a_qin_d[ch*DW +: DW] = d;
    a_qin_e[ch]  = e;
    a_qin_v[ch]  = v;
    a_qout_b[ch] = b;
  endtask

  vec_t tbl[$];
  vec_t t;
  int   sent;
  int   rcvd;
  int   cyc;
  logic rb;
  logic wr;

  initial begin
    // ch0 fill/drain with overflow, ch1 read+write at full, ch2 end tokens, ch4 write at empty / pass-through
    tbl.push_back(mk(0, 1, 16'h0001, 0, 1, 1, 0, 1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0002, 0, 1, 2, 0, 1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0003, 0, 1, 3, 0, 1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0004, 0, 1, 4, 1, 1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0005, 0, 1, 4, 1, 1, 16'h0001, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 3, 0, 1, 16'h0002, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 2, 0, 1, 16'h0003, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0004, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'h0011, 0, 1, 1, 0, 1, 16'h0011, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0012, 0, 1, 2, 0, 1, 16'h0011, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0013, 0, 1, 3, 0, 1, 16'h0011, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0014, 0, 1, 4, 1, 1, 16'h0011, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0015, 0, 0, 3, 0, 1, 16'h0012, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 2, 0, 1, 16'h0013, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0014, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(2, 1, 16'h00AA, 0, 1, 1, 0, 1, 16'h00AA, 0, 0, 0));
    tbl.push_back(mk(2, 1, 16'h00BB, 1, 1, 2, 0, 1, 16'h00AA, 0, 0, 1));
    tbl.push_back(mk(2, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h00BB, 1, 0, 1));
    tbl.push_back(mk(2, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(4, 1, 16'h0041, 0, 0, 1, 0, 1, 16'h0041, 0, 0, 0));
    tbl.push_back(mk(4, 1, 16'h0042, 1, 0, 1, 0, 1, 16'h0042, 1, 0, 1));
    tbl.push_back(mk(4, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));

    reset = 1'b0;
    drive_a(0, 0, 16'h0, 0, 1);
    b_qin_d = '0; b_qin_e = '0; b_qin_v = '0; b_qout_b = '1;
    #2;
    chk("rst_qin_b_held", 32'(a_qin_b), 32'hFF);
    #10 reset = 1'b1;
    step();
    chk("rst_qout_v", 32'(a_qout_v), 32'h0);
    chk("rst_occ",    32'(a_occ),    32'h0);
    chk("rst_qin_b",  32'(a_qin_b),  32'h0);
    chk("rst_ovf",    32'(a_ovf),    32'h0);
    chk("rst_eos",    32'(a_eos),    32'h0);
    chk("rst_b_qin_b", 32'(b_qin_b), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      drive_a(t.ch, t.v, t.d, t.e, t.b);
      step();
      chk($sformatf("v%0d_occ", i),  32'(a_occ[t.ch*CW +: CW]), 32'(t.occ));
      chk($sformatf("v%0d_qin_b", i), 32'(a_qin_b[t.ch]),  32'(t.qb));
      chk($sformatf("v%0d_qout_v", i), 32'(a_qout_v[t.ch]), 32'(t.qv));
      chk($sformatf("v%0d_ovf", i),  32'(a_ovf[t.ch]),    32'(t.ovf));
      chk($sformatf("v%0d_eos", i),  32'(a_eos[t.ch]),    32'(t.eos));
      if (t.qv) begin
        chk($sformatf("v%0d_qout_d", i), 32'(a_qout_d[t.ch*DW +: DW]), 32'(t.qd));
        chk($sformatf("v%0d_qout_e", i), 32'(a_qout_e[t.ch]), 32'(t.qe));
      end
    end
    drive_a(0, 0, 16'h0, 0, 1);

    // Lookahead: threshold at 8-2=6, two further writes absorbed, the ninth lost
    b_qin_v = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      b_qin_d = 16'(k);
      step();
      chk($sformatf("la%0d_occ", k),   32'(b_occ),   32'((k > 8) ? 8 : k));
      chk($sformatf("la%0d_qin_b", k), 32'(b_qin_b), 32'((k >= 6) ? 1 : 0));
      chk($sformatf("la%0d_ovf", k),   32'(b_ovf),   32'((k >= 9) ? 1 : 0));
    end
    b_qin_v = 1'b0;
    chk("la_head", 32'(b_qout_d), 32'h1);

    // ch3 streams 20 words honouring qin_b, consumer stalls in 3-cycle runs
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 20 && cyc < 300) begin
      rb = ((cyc / 3) % 2) == 1;
      wr = (sent < 20) && !a_qin_b[3];
      if (a_qout_v[3] && !rb) begin
        chk($sformatf("stream_d%0d", rcvd), 32'(a_qout_d[3*DW +: DW]), 32'(16'h3000 + rcvd));
        rcvd++;
      end
      drive_a(3, wr, 16'(16'h3000 + sent), 1'b0, rb);
      if (wr) sent++;
      chk($sformatf("idle_others_c%0d", cyc),
          32'({|(a_occ & 24'hFFF1FF), |(a_qin_b & 8'hF7), |(a_qout_v & 8'hF7)}), 32'h0);
      step();
      cyc++;
    end
    chk("stream_count", 32'(rcvd), 32'd20);
    chk("stream_ovf",   32'(a_ovf[3]), 32'h0);
    drive_a(0, 0, 16'h0, 0, 1);
    step();
    chk("stream_empty", 32'(a_occ[3*CW +: CW]), 32'h0);

    // Async reset with ch0 holding 3 words and ovf set
    for (int k = 0; k < 3; k++) begin
      drive_a(0, 1, 16'(16'h0070 + k), 1'b0, 1'b1);
      step();
    end
    drive_a(0, 0, 16'h0, 0, 1);
    chk("pre_rst_occ", 32'(a_occ[CW-1:0]), 32'd3);
    chk("pre_rst_ovf", 32'(a_ovf[0]), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_qout_v", 32'(a_qout_v), 32'h0);
    chk("arst_occ",    32'(a_occ),    32'h0);
    chk("arst_ovf",    32'(a_ovf),    32'h0);
    chk("arst_qin_b",  32'(a_qin_b),  32'hFF);
    chk("arst_b_qin_b", 32'(b_qin_b), 32'h1);
    step();
    chk("arst_hold_qin_b", 32'(a_qin_b), 32'hFF);
    #2 reset = 1'b1;
    #1;
    chk("rel_qin_b", 32'(a_qin_b), 32'h0);
    step();
    chk("post_rel_qin_b", 32'(a_qin_b), 32'h0);
    chk("post_rel_occ",   32'(a_occ),   32'h0);
    chk("post_rel_b_occ", 32'(b_occ),   32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
